// File: rtl/rom_ctrl_sink_pkg.sv
// rom_ctrl_sink_pkg: shared state encoding and sizing helper for the ROM checker word sink.
package rom_ctrl_sink_pkg;

   typedef enum logic [1:0] {StHash, StTop, StDone, StErr} sink_state_e;

   function automatic int unsigned calc_nontop(input int unsigned depth, input int unsigned top_count);
      return depth - top_count;
   endfunction

endpackage

// File: rtl/rom_ctrl_sink_obuf.sv
// rom_ctrl_sink_obuf: one-entry registered valid/ready output stage.
module rom_ctrl_sink_obuf #(
   parameter int unsigned W = 41
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = load_i | (valid_q & ~ready_i);
      data_d  = load_i ? data_i : (valid_q & ready_i) ? '0 : data_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/rom_ctrl_word_sink.sv
// rom_ctrl_word_sink: forwards non-top ROM words to KMAC, captures the top words as the
// expected digest and flags out-of-order or mis-tagged words.
module rom_ctrl_word_sink
   import rom_ctrl_sink_pkg::*;
#(
   parameter  int unsigned RomDepth    = 16,
   parameter  int unsigned RomTopCount = 2,
   parameter  int unsigned DW          = 40,
   localparam int unsigned AW          = RomDepth > 1 ? $clog2(RomDepth) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      word_vld_i,
   output logic                      word_rdy_o,
   input  logic [AW-1:0]             word_addr_i,
   input  logic [DW-1:0]             word_data_i,
   input  logic                      word_last_nontop_i,
   output logic                      kmac_valid_o,
   output logic [DW-1:0]             kmac_data_o,
   output logic                      kmac_last_o,
   input  logic                      kmac_ready_i,
   output logic [RomTopCount*DW-1:0] exp_digest_o,
   output logic                      exp_vld_o,
   output logic                      err_o
);

   localparam int unsigned NonTop = calc_nontop(RomDepth, RomTopCount);

   sink_state_e   state_q, state_d;
   logic [AW-1:0] exp_addr_q, exp_addr_d;
   logic          xfer, ok, load, cap;
   logic [DW:0]   obuf_q;

   always_comb begin
      word_rdy_o = state_q == StHash ? (~kmac_valid_o | kmac_ready_i) : state_q == StTop;
      xfer       = word_vld_i & word_rdy_o;
      ok         = (word_addr_i == exp_addr_q) &
                   (word_last_nontop_i == (word_addr_i == AW'(NonTop - 1)));
      load       = xfer & ok & (state_q == StHash);
      cap        = xfer & ok & (state_q == StTop);
      exp_addr_d = (load | cap) ? exp_addr_q + AW'(1) : exp_addr_q;
      state_d    = state_q;
      if (xfer && !ok) state_d = StErr;
      else if (load && word_last_nontop_i) state_d = StTop;
      else if (cap && word_addr_i == AW'(RomDepth - 1)) state_d = StDone;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StHash;
         exp_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         exp_addr_q <= exp_addr_d;
      end
   end

   rom_ctrl_sink_obuf #(.W(DW + 1)) u_obuf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .data_i  ({word_last_nontop_i, word_data_i}),
      .ready_i (kmac_ready_i),
      .valid_o (kmac_valid_o),
      .data_o  (obuf_q)
   );

   assign kmac_last_o = obuf_q[DW];
   assign kmac_data_o = obuf_q[DW-1:0];

   // Slot k holds the word at address NonTop + k.
   for (genvar k = 0; k < RomTopCount; k++) begin : g_slot
      logic [DW-1:0] slot_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) slot_q <= '0;
         else if (cap && word_addr_i == AW'(NonTop + k)) slot_q <= word_data_i;
      end
      assign exp_digest_o[k*DW +: DW] = slot_q;
   end

   assign exp_vld_o = state_q == StDone;
   assign err_o     = state_q == StErr;

   a_kmac_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      kmac_valid_o && !kmac_ready_i |=> kmac_valid_o && $stable(kmac_data_o) && $stable(kmac_last_o));
   a_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(exp_vld_o && err_o));
   a_vld_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni) exp_vld_o |=> exp_vld_o);
   a_err_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni) err_o |=> err_o);

endmodule

// File: tb/tb_rom_ctrl_word_sink.sv
// tb_rom_ctrl_word_sink: table-driven check of a small configuration plus model-checked
// randomized and corner-case streams on the default configuration.
module tb_rom_ctrl_word_sink;
   localparam int D = 16, T = 2, DW = 40, NT = D - T, AW = 4;
   localparam int D2 = 8, T2 = 3, AW2 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_ni, vld, last, kr, rdy, kv, kl, ev, er;
   logic [AW-1:0] addr;
   logic [DW-1:0] data, kd;
   logic [T*DW-1:0] dig;

   logic b_rst_n, b_vld, b_last, b_kr, b_rdy, b_kv, b_kl, b_ev, b_er;
   logic [AW2-1:0] b_addr;
   logic [DW-1:0] b_data, b_kd;
   logic [T2*DW-1:0] b_dig;

   rom_ctrl_word_sink #(.RomDepth(D), .RomTopCount(T), .DW(DW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .word_vld_i(vld), .word_rdy_o(rdy), .word_addr_i(addr),
      .word_data_i(data), .word_last_nontop_i(last), .kmac_valid_o(kv), .kmac_data_o(kd),
      .kmac_last_o(kl), .kmac_ready_i(kr), .exp_digest_o(dig), .exp_vld_o(ev), .err_o(er));

   rom_ctrl_word_sink #(.RomDepth(D2), .RomTopCount(T2), .DW(DW)) dut2 (
      .clk_i(clk), .rst_ni(b_rst_n), .word_vld_i(b_vld), .word_rdy_o(b_rdy), .word_addr_i(b_addr),
      .word_data_i(b_data), .word_last_nontop_i(b_last), .kmac_valid_o(b_kv), .kmac_data_o(b_kd),
      .kmac_last_o(b_kl), .kmac_ready_i(b_kr), .exp_digest_o(b_dig), .exp_vld_o(b_ev), .err_o(b_er));

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stream position, held output word, captured digest, outcome flags.
   bit m_held, m_last, m_err, m_done, saw_last;
   logic [DW-1:0] m_word;
   logic [DW-1:0] m_dig [T];
   int m_next;
   logic [DW-1:0] exp_q[$], fwd_q[$];

   function automatic logic [DW-1:0] rnd();
      return {8'($urandom()), $urandom()};
   endfunction

   task automatic m_reset();
      m_held = 0; m_last = 0; m_err = 0; m_done = 0; saw_last = 0; m_word = '0; m_next = 0;
      for (int k = 0; k < T; k++) m_dig[k] = '0;
      exp_q.delete();
      fwd_q.delete();
   endtask

   task automatic step();
      bit m_rdy, drain, loaded;
      logic [T*DW-1:0] md;
      @(negedge clk);
      m_rdy = !m_err && !m_done && (m_next >= NT || !m_held || kr);
      for (int k = 0; k < T; k++) md[k*DW +: DW] = m_dig[k];
      chk("word_rdy", rdy, m_rdy);
      chk("kmac_valid", kv, m_held);
      if (m_held) begin
         chk("kmac_data", kd, m_word);
         chk("kmac_last", kl, m_last);
      end
      chk("exp_vld", ev, m_done);
      chk("err", er, m_err);
      chk("digest", dig, md);
      if (kv && kr) fwd_q.push_back(kd);
      if (kv && kl) saw_last = 1;
      drain = m_held && kr;
      loaded = 0;
      if (vld && m_rdy) begin
         if (int'(addr) == m_next && last == (int'(addr) == NT - 1)) begin
            if (m_next < NT) begin
               loaded = 1; m_held = 1; m_word = data; m_last = last;
               exp_q.push_back(data);
            end else m_dig[int'(addr) - NT] = data;
            m_next++;
            if (m_next == D) m_done = 1;
         end else m_err = 1;
      end
      if (!loaded && drain) m_held = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      vld = 0; kr = 1; last = 0; addr = '0; data = '0;
      rst_ni = 0;
      #1;
      chk("rst_rdy", rdy, 1);
      chk("rst_kvalid", kv, 0);
      chk("rst_kdata", kd, 0);
      chk("rst_klast", kl, 0);
      chk("rst_digest", dig, 0);
      chk("rst_exp_vld", ev, 0);
      chk("rst_err", er, 0);
      m_reset();
      @(posedge clk);
      #1;
      rst_ni = 1;
   endtask

   // Offers words in address order until stop, done or error; err_kind 1 skips an address,
   // err_kind 2 sets the last-non-top tag at err_at.
   task automatic run_stream(input int vld_pct, input int kr_pct, input int err_kind,
                             input int err_at, input int stop);
      int budget = 0;
      while (!m_done && !m_err && m_next < stop && budget < 400) begin
         vld = $urandom_range(99) < vld_pct;
         kr = $urandom_range(99) < kr_pct;
         addr = AW'(m_next);
         last = m_next == NT - 1;
         data = rnd();
         if (err_kind == 1 && m_next == err_at) addr = AW'(m_next + 1);
         if (err_kind == 2 && m_next == err_at) last = 1;
         step();
         budget++;
      end
      chk("stream_in_budget", budget < 400, 1);
   endtask

   task automatic finish_stream();
      vld = 1; kr = 1; addr = AW'(m_next); last = 0;
      repeat (3) step();
      vld = 0;
      chk("fwd_count", fwd_q.size(), exp_q.size());
      for (int i = 0; i < fwd_q.size() && i < exp_q.size(); i++) chk("fwd_word", fwd_q[i], exp_q[i]);
   endtask

   typedef struct {
      logic vld; logic [AW2-1:0] addr; logic last; logic kr;
      logic rdy; logic kv; logic [AW2-1:0] ka; logic kl; logic ev;
   } vec_t;

   function automatic vec_t mkv(int v, int a, int l, int r, int rd, int k, int ka, int kl2, int e);
      vec_t t;
      t.vld = 1'(v); t.addr = AW2'(a); t.last = 1'(l); t.kr = 1'(r);
      t.rdy = 1'(rd); t.kv = 1'(k); t.ka = AW2'(ka); t.kl = 1'(kl2); t.ev = 1'(e);
      return t;
   endfunction

   function automatic logic [DW-1:0] w2(int a);
      return 40'hC0DE000000 + DW'(a);
   endfunction

   initial begin
      vec_t tv [11];
      tv[0]  = mkv(1, 0, 0, 1, 1, 0, 0, 0, 0);
      tv[1]  = mkv(1, 1, 0, 1, 1, 1, 0, 0, 0);
      tv[2]  = mkv(1, 2, 0, 0, 0, 1, 1, 0, 0);
      tv[3]  = mkv(1, 2, 0, 1, 1, 1, 1, 0, 0);
      tv[4]  = mkv(1, 3, 0, 1, 1, 1, 2, 0, 0);
      tv[5]  = mkv(1, 4, 1, 1, 1, 1, 3, 0, 0);
      tv[6]  = mkv(1, 5, 0, 1, 1, 1, 4, 1, 0);
      tv[7]  = mkv(1, 6, 0, 1, 1, 0, 0, 0, 0);
      tv[8]  = mkv(1, 7, 0, 1, 1, 0, 0, 0, 0);
      tv[9]  = mkv(0, 0, 0, 1, 0, 0, 0, 0, 1);
      tv[10] = mkv(1, 0, 0, 1, 0, 0, 0, 0, 1);

      rst_ni = 0; vld = 0; kr = 1; last = 0; addr = '0; data = '0;
      b_rst_n = 0; b_vld = 0; b_kr = 1; b_last = 0; b_addr = '0; b_data = '0;
      m_reset();
      #2;
      chk("b_rst_kvalid", b_kv, 0);
      chk("b_rst_digest", b_dig, 0);
      chk("b_rst_err", b_er, 0);
      @(posedge clk);
      #1;
      b_rst_n = 1;
      for (int i = 0; i < 11; i++) begin
         b_vld = tv[i].vld; b_addr = tv[i].addr; b_last = tv[i].last; b_kr = tv[i].kr;
         b_data = w2(int'(tv[i].addr));
         @(negedge clk);
         chk("b_rdy", b_rdy, tv[i].rdy);
         chk("b_kvalid", b_kv, tv[i].kv);
         if (tv[i].kv) begin
            chk("b_kdata", b_kd, w2(int'(tv[i].ka)));
            chk("b_klast", b_kl, tv[i].kl);
         end
         chk("b_exp_vld", b_ev, tv[i].ev);
         chk("b_err", b_er, 0);
         @(posedge clk);
         #1;
      end
      chk("b_digest", b_dig, {w2(7), w2(6), w2(5)});

      do_reset();
      run_stream(100, 100, 0, 0, D);
      finish_stream();
      chk("inorder_last_seen", saw_last, 1);

      do_reset();
      run_stream(100, 100, 0, 0, 4);
      vld = 1; addr = 4'd4; last = 0; kr = 0;
      repeat (5) step();
      run_stream(100, 100, 0, 0, D);
      finish_stream();
      chk("bp_done", ev, 1);

      do_reset();
      run_stream(100, 100, 1, 4, D);
      finish_stream();
      chk("skip_err", er, 1);
      chk("skip_fwd", fwd_q.size(), 4);

      do_reset();
      run_stream(100, 100, 2, 12, D);
      finish_stream();
      chk("badtag_err", er, 1);
      chk("badtag_no_last", saw_last, 0);

      do_reset();
      run_stream(100, 100, 0, 0, 8);
      do_reset();
      run_stream(100, 100, 0, 0, D);
      finish_stream();
      chk("restart_done", ev, 1);

      repeat (8) begin
         do_reset();
         run_stream(70, 60, $urandom_range(2), $urandom_range(D - 1), D);
         finish_stream();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
